// File: rtl/editor_valores_if.sv
// Edit-value bus between the display edit FSM / RTC side (master) and editor_valores (slave).
interface editor_valores_if;
  logic [1:0]  edit_mode;
  logic [1:0]  edit_pos;
  logic [3:0]  boton_ed;
  logic [23:0] rtc_time_in;
  logic [23:0] rtc_date_in;
  logic [23:0] rtc_timer_in;
  logic [23:0] edit_time;
  logic [23:0] edit_date;
  logic [23:0] edit_timer;
  logic        wr_time;
  logic        wr_date;
  logic        wr_timer;
  logic        editing;

  modport master (
    output edit_mode, edit_pos, boton_ed, rtc_time_in, rtc_date_in, rtc_timer_in,
    input  edit_time, edit_date, edit_timer, wr_time, wr_date, wr_timer, editing
  );

  modport slave (
    input  edit_mode, edit_pos, boton_ed, rtc_time_in, rtc_date_in, rtc_timer_in,
    output edit_time, edit_date, edit_timer, wr_time, wr_date, wr_timer, editing
  );
endinterface

// File: rtl/editor_valores.sv
// BCD working copies of time/date/timer, stepped by Up/Down with wrap and calendar limits.
// Optional hold-to-repeat stepping is enabled by defining EDITOR_AUTOREPEAT_EN.
module editor_valores #(
  parameter int unsigned REPEAT_DELAY  = 50_000_000,
  parameter int unsigned REPEAT_PERIOD = 10_000_000
) (
  input  logic             clk,
  input  logic             reset,
  editor_valores_if.slave  bus
);

  localparam logic [1:0] MODE_IDLE  = 2'b00;
  localparam logic [1:0] MODE_TIMER = 2'b01;
  localparam logic [1:0] MODE_DATE  = 2'b10;
  localparam logic [1:0] MODE_TIME  = 2'b11;

  localparam logic [1:0] POS_A    = 2'b11;
  localparam logic [1:0] POS_B    = 2'b10;
  localparam logic [1:0] POS_C    = 2'b01;
  localparam logic [1:0] POS_NONE = 2'b00;

  logic [1:0]  mode_q_reg;
  logic [1:0]  btn_q_reg;
  logic [23:0] time_reg, time_next;
  logic [23:0] date_reg, date_next;
  logic [23:0] timer_reg, timer_next;
  logic [2:0]  wr_reg;
  logic        editing_reg;

  // Group index gi maps to edit_mode value gi+1: 0 timer, 1 date, 2 time.
  logic [2:0]  load_grp;
  logic [2:0]  commit_grp;
  logic        steady;
  logic        edit_active;
  logic [1:0]  press;
  logic        rpt_up, rpt_dn;
  logic        step_up, step_dn, do_step;
  logic [7:0]  new_dd, new_mo, new_yy, dd_max;
  logic        unused_btn_bits;

  assign unused_btn_bits = ^bus.boton_ed[3:2];

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_grp
      assign load_grp[gi]   = (bus.edit_mode == 2'(gi + 1)) && (mode_q_reg != bus.edit_mode);
      assign commit_grp[gi] = (mode_q_reg == 2'(gi + 1)) && (bus.edit_mode != mode_q_reg);
    end
  endgenerate

  assign steady      = (mode_q_reg != MODE_IDLE) && (bus.edit_mode == mode_q_reg);
  assign edit_active = steady && (bus.edit_pos != POS_NONE);
  assign press       = bus.boton_ed[1:0] & ~btn_q_reg;
  assign step_up     = edit_active && ((press == 2'b01) || rpt_up);
  assign step_dn     = edit_active && ((press == 2'b10) || rpt_dn);
  assign do_step     = step_up || step_dn;

  function automatic logic bcd_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  // Out-of-range or non-BCD values snap to lo on Up and to hi on Down.
  function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic up,
                                          input logic [7:0] lo, input logic [7:0] hi);
    logic       in_range;
    logic [7:0] r;
    in_range = bcd_ok(v) && (v >= lo) && (v <= hi);
    if (up) begin
      if (!in_range || v == hi) r = lo;
      else if (v[3:0] == 4'd9)  r = {v[7:4] + 4'd1, 4'd0};
      else                      r = {v[7:4], v[3:0] + 4'd1};
    end else begin
      if (!in_range || v == lo) r = hi;
      else if (v[3:0] == 4'd0)  r = {v[7:4] - 4'd1, 4'd9};
      else                      r = {v[7:4], v[3:0] - 4'd1};
    end
    return r;
  endfunction

  // BCD yy mod 4 == 0 iff (even tens, ones in 0/4/8) or (odd tens, ones in 2/6).
  function automatic logic [7:0] day_max(input logic [7:0] mo, input logic [7:0] yy);
    logic leap;
    leap = yy[4] ? ((yy[3:0] == 4'd2) || (yy[3:0] == 4'd6))
                 : ((yy[3:0] == 4'd0) || (yy[3:0] == 4'd4) || (yy[3:0] == 4'd8));
    case (mo)
      8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
      8'h02:                      return leap ? 8'h29 : 8'h28;
      default:                    return 8'h31;
    endcase
  endfunction

  always_comb begin
    new_dd = date_reg[23:16];
    new_mo = date_reg[15:8];
    new_yy = date_reg[7:0];
    case (bus.edit_pos)
      POS_A:   new_dd = bcd_step(date_reg[23:16], step_up, 8'h01,
                                 day_max(date_reg[15:8], date_reg[7:0]));
      POS_B:   new_mo = bcd_step(date_reg[15:8], step_up, 8'h01, 8'h12);
      POS_C:   new_yy = bcd_step(date_reg[7:0], step_up, 8'h00, 8'h99);
      default: ;
    endcase
    dd_max = day_max(new_mo, new_yy);
    if ((bus.edit_pos != POS_A) && (new_dd > dd_max))
      new_dd = dd_max;
  end

  always_comb begin
    time_next  = time_reg;
    date_next  = date_reg;
    timer_next = timer_reg;
    if (load_grp[2]) time_next  = bus.rtc_time_in;
    if (load_grp[1]) date_next  = bus.rtc_date_in;
    if (load_grp[0]) timer_next = bus.rtc_timer_in;
    if (do_step) begin
      case (mode_q_reg)
        MODE_TIME: begin
          case (bus.edit_pos)
            POS_A:   time_next[23:16] = bcd_step(time_reg[23:16], step_up, 8'h00, 8'h23);
            POS_B:   time_next[15:8]  = bcd_step(time_reg[15:8],  step_up, 8'h00, 8'h59);
            POS_C:   time_next[7:0]   = bcd_step(time_reg[7:0],   step_up, 8'h00, 8'h59);
            default: ;
          endcase
        end
        MODE_TIMER: begin
          case (bus.edit_pos)
            POS_A:   timer_next[23:16] = bcd_step(timer_reg[23:16], step_up, 8'h00, 8'h23);
            POS_B:   timer_next[15:8]  = bcd_step(timer_reg[15:8],  step_up, 8'h00, 8'h59);
            POS_C:   timer_next[7:0]   = bcd_step(timer_reg[7:0],   step_up, 8'h00, 8'h59);
            default: ;
          endcase
        end
        MODE_DATE: date_next = {new_dd, new_mo, new_yy};
        default: ;
      endcase
    end
  end

`ifdef EDITOR_AUTOREPEAT_EN
  logic [31:0] rpt_cnt_reg;
  logic [31:0] rpt_target_reg;
  logic        held_one;
  logic        rpt_hit;

  assign held_one = (bus.boton_ed[1:0] == 2'b01) || (bus.boton_ed[1:0] == 2'b10);
  assign rpt_hit  = edit_active && held_one && (rpt_cnt_reg != 32'd0) &&
                    (rpt_cnt_reg == rpt_target_reg);
  assign rpt_up   = rpt_hit && bus.boton_ed[0];
  assign rpt_dn   = rpt_hit && bus.boton_ed[1];

  // Counter is 1 on the cycle after the press, so a hit at value N is N cycles after it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rpt_cnt_reg    <= 32'd0;
      rpt_target_reg <= REPEAT_DELAY;
    end else if (!(edit_active && held_one)) begin
      rpt_cnt_reg    <= 32'd0;
      rpt_target_reg <= REPEAT_DELAY;
    end else if (press != 2'b00) begin
      rpt_cnt_reg    <= 32'd1;
      rpt_target_reg <= REPEAT_DELAY;
    end else if (rpt_cnt_reg != 32'd0) begin
      rpt_cnt_reg <= rpt_cnt_reg + 32'd1;
      if (rpt_hit)
        rpt_target_reg <= rpt_target_reg + REPEAT_PERIOD;
    end
  end
`else
  localparam int unsigned unused_repeat_cfg = REPEAT_DELAY + REPEAT_PERIOD;
  assign rpt_up = 1'b0;
  assign rpt_dn = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q_reg  <= MODE_IDLE;
      btn_q_reg   <= 2'b00;
      time_reg    <= 24'h000000;
      date_reg    <= 24'h010100;
      timer_reg   <= 24'h000000;
      wr_reg      <= 3'b000;
      editing_reg <= 1'b0;
    end else begin
      mode_q_reg  <= bus.edit_mode;
      btn_q_reg   <= bus.boton_ed[1:0];
      time_reg    <= time_next;
      date_reg    <= date_next;
      timer_reg   <= timer_next;
      wr_reg      <= commit_grp;
      editing_reg <= (bus.edit_mode != MODE_IDLE);
    end
  end

  assign bus.edit_time  = time_reg;
  assign bus.edit_date  = date_reg;
  assign bus.edit_timer = timer_reg;
  assign bus.wr_time    = wr_reg[2];
  assign bus.wr_date    = wr_reg[1];
  assign bus.wr_timer   = wr_reg[0];
  assign bus.editing    = editing_reg;

endmodule

// File: tb/tb_editor_valores.sv
// Directed bench for editor_valores: stimulus pushes expected state, a negedge monitor checks it.
module tb_editor_valores;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  editor_valores_if vif ();

  editor_valores dut (
    .clk   (clk),
    .reset (reset),
    .bus   (vif)
  );

  typedef struct packed {
    logic [23:0] t;
    logic [23:0] d;
    logic [23:0] r;
    logic [2:0]  wr;
    logic        ed;
  } exp_t;

  exp_t  sb_q[$];
  string lbl_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  task automatic push_exp(input string lbl, input logic [23:0] t, input logic [23:0] d,
                          input logic [23:0] r, input logic [2:0] wr, input logic ed);
    exp_t e;
    e.t = t; e.d = d; e.r = r; e.wr = wr; e.ed = ed;
    sb_q.push_back(e);
    lbl_q.push_back(lbl);
  endtask

  // Expectation for the state right after the next rising edge.
  task automatic cyc(input string lbl, input logic [23:0] t, input logic [23:0] d,
                     input logic [23:0] r, input logic [2:0] wr, input logic ed);
    @(posedge clk);
    #1;
    push_exp(lbl, t, d, r, wr, ed);
  endtask

  task automatic chk(input string lbl, input string what, input logic [23:0] act,
                     input logic [23:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s %s: got %h, expected %h", lbl, what, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t  e;
    string l;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      l = lbl_q.pop_front();
      chk(l, "edit_time",  vif.edit_time,  e.t);
      chk(l, "edit_date",  vif.edit_date,  e.d);
      chk(l, "edit_timer", vif.edit_timer, e.r);
      chk(l, "wr{time,date,timer}", {21'd0, vif.wr_time, vif.wr_date, vif.wr_timer}, {21'd0, e.wr});
      chk(l, "editing", {23'd0, vif.editing}, {23'd0, e.ed});
      $display("[TB] %-20s time=%h date=%h timer=%h wr=%b%b%b editing=%b", l,
               vif.edit_time, vif.edit_date, vif.edit_timer,
               vif.wr_time, vif.wr_date, vif.wr_timer, vif.editing);
    end
  end

  initial begin
    vif.edit_mode    = 2'b00;
    vif.edit_pos     = 2'b00;
    vif.boton_ed     = 4'b0000;
    vif.rtc_time_in  = 24'h235958;
    vif.rtc_date_in  = 24'h310123;
    vif.rtc_timer_in = 24'h120500;

    cyc("reset0", 24'h000000, 24'h010100, 24'h000000, 3'b000, 1'b0);
    cyc("reset1", 24'h000000, 24'h010100, 24'h000000, 3'b000, 1'b0);
    reset = 1'b1;
    cyc("idle", 24'h000000, 24'h010100, 24'h000000, 3'b000, 1'b0);

    // Time edit
    vif.edit_mode = 2'b11;
    cyc("time_entry", 24'h235958, 24'h010100, 24'h000000, 3'b000, 1'b1);
    vif.edit_pos = 2'b11; vif.boton_ed = 4'b0001;
    cyc("hh_up_wrap", 24'h005958, 24'h010100, 24'h000000, 3'b000, 1'b1);
    vif.boton_ed = 4'b0000;
    cyc("hh_release", 24'h005958, 24'h010100, 24'h000000, 3'b000, 1'b1);
    vif.boton_ed = 4'b1100;
    cyc("ignored_btns", 24'h005958, 24'h010100, 24'h000000, 3'b000, 1'b1);
    vif.boton_ed = 4'b0000;
    cyc("ignored_release", 24'h005958, 24'h010100, 24'h000000, 3'b000, 1'b1);
    vif.edit_pos = 2'b01; vif.boton_ed = 4'b0001;
    cyc("ss_up", 24'h005959, 24'h010100, 24'h000000, 3'b000, 1'b1);
    vif.boton_ed = 4'b0000;
    cyc("ss_release", 24'h005959, 24'h010100, 24'h000000, 3'b000, 1'b1);
    vif.boton_ed = 4'b0001;
    cyc("ss_up_wrap", 24'h005900, 24'h010100, 24'h000000, 3'b000, 1'b1);
    vif.boton_ed = 4'b0000;
    cyc("ss_release2", 24'h005900, 24'h010100, 24'h000000, 3'b000, 1'b1);
    vif.edit_pos = 2'b10; vif.boton_ed = 4'b0010;
    cyc("mm_dn", 24'h005800, 24'h010100, 24'h000000, 3'b000, 1'b1);
    vif.boton_ed = 4'b0000;
    cyc("mm_release", 24'h005800, 24'h010100, 24'h000000, 3'b000, 1'b1);
    vif.edit_pos = 2'b00; vif.boton_ed = 4'b0001;
    cyc("pos_none", 24'h005800, 24'h010100, 24'h000000, 3'b000, 1'b1);
    vif.boton_ed = 4'b0000;
    cyc("pos_none_rel", 24'h005800, 24'h010100, 24'h000000, 3'b000, 1'b1);
    vif.edit_mode = 2'b00;
    cyc("exit_time", 24'h005800, 24'h010100, 24'h000000, 3'b100, 1'b0);
    cyc("wr_time_once", 24'h005800, 24'h010100, 24'h000000, 3'b000, 1'b0);

    // Date edit: month change clamps the day
    vif.edit_mode = 2'b10;
    cyc("date_entry", 24'h005800, 24'h310123, 24'h000000, 3'b000, 1'b1);
    vif.edit_pos = 2'b10; vif.boton_ed = 4'b0001;
    cyc("mo_clamp28", 24'h005800, 24'h280223, 24'h000000, 3'b000, 1'b1);
    vif.boton_ed = 4'b0000;
    cyc("mo_release", 24'h005800, 24'h280223, 24'h000000, 3'b000, 1'b1);
    vif.edit_mode = 2'b00;
    cyc("exit_date", 24'h005800, 24'h280223, 24'h000000, 3'b010, 1'b0);
    vif.rtc_date_in = 24'h310124; vif.edit_mode = 2'b10;
    cyc("date_reentry", 24'h005800, 24'h310124, 24'h000000, 3'b000, 1'b1);
    vif.boton_ed = 4'b0001;
    cyc("mo_clamp29", 24'h005800, 24'h290224, 24'h000000, 3'b000, 1'b1);
    vif.boton_ed = 4'b0000;
    cyc("mo_release2", 24'h005800, 24'h290224, 24'h000000, 3'b000, 1'b1);
    vif.edit_pos = 2'b01; vif.boton_ed = 4'b0010;
    cyc("yy_dn_clamp", 24'h005800, 24'h280223, 24'h000000, 3'b000, 1'b1);
    vif.boton_ed = 4'b0000;
    cyc("yy_release", 24'h005800, 24'h280223, 24'h000000, 3'b000, 1'b1);
    vif.edit_pos = 2'b11; vif.boton_ed = 4'b0001;
    cyc("dd_up_wrap", 24'h005800, 24'h010223, 24'h000000, 3'b000, 1'b1);
    vif.boton_ed = 4'b0000;
    cyc("dd_release", 24'h005800, 24'h010223, 24'h000000, 3'b000, 1'b1);

    // Direct switch date -> timer
    vif.edit_mode = 2'b01;
    cyc("date_to_timer", 24'h005800, 24'h010223, 24'h120500, 3'b010, 1'b1);
    cyc("wr_date_once", 24'h005800, 24'h010223, 24'h120500, 3'b000, 1'b1);
    vif.edit_pos = 2'b01; vif.boton_ed = 4'b0010;
    cyc("ts_dn_wrap", 24'h005800, 24'h010223, 24'h120559, 3'b000, 1'b1);
    vif.boton_ed = 4'b0000;
    cyc("ts_release", 24'h005800, 24'h010223, 24'h120559, 3'b000, 1'b1);
    vif.boton_ed = 4'b0011;
    cyc("up_dn_together", 24'h005800, 24'h010223, 24'h120559, 3'b000, 1'b1);
    vif.boton_ed = 4'b0000;
    cyc("both_release", 24'h005800, 24'h010223, 24'h120559, 3'b000, 1'b1);
    vif.edit_pos = 2'b11; vif.boton_ed = 4'b0001;
    cyc("th_up", 24'h005800, 24'h010223, 24'h130559, 3'b000, 1'b1);
    vif.boton_ed = 4'b0000;
    cyc("th_release", 24'h005800, 24'h010223, 24'h130559, 3'b000, 1'b1);
    vif.edit_pos = 2'b10; vif.boton_ed = 4'b0010;
    cyc("tm_dn", 24'h005800, 24'h010223, 24'h130459, 3'b000, 1'b1);
    vif.boton_ed = 4'b0000;
    cyc("tm_release", 24'h005800, 24'h010223, 24'h130459, 3'b000, 1'b1);
    vif.edit_mode = 2'b00;
    cyc("exit_timer", 24'h005800, 24'h010223, 24'h130459, 3'b001, 1'b0);
    cyc("wr_timer_once", 24'h005800, 24'h010223, 24'h130459, 3'b000, 1'b0);

    // Out-of-range values snap to min/max
    vif.rtc_time_in = 24'h2A6099; vif.edit_mode = 2'b11;
    cyc("time_bad_entry", 24'h2A6099, 24'h010223, 24'h130459, 3'b000, 1'b1);
    vif.edit_pos = 2'b11; vif.boton_ed = 4'b0001;
    cyc("hh_invalid_up", 24'h006099, 24'h010223, 24'h130459, 3'b000, 1'b1);
    vif.boton_ed = 4'b0000;
    cyc("hh_inv_release", 24'h006099, 24'h010223, 24'h130459, 3'b000, 1'b1);
    vif.edit_pos = 2'b10; vif.boton_ed = 4'b0010;
    cyc("mm_oor_dn", 24'h005999, 24'h010223, 24'h130459, 3'b000, 1'b1);
    vif.boton_ed = 4'b0000;
    cyc("mm_oor_release", 24'h005999, 24'h010223, 24'h130459, 3'b000, 1'b1);
    vif.edit_mode = 2'b00;
    cyc("exit_time2", 24'h005999, 24'h010223, 24'h130459, 3'b100, 1'b0);
    cyc("wr_time_once2", 24'h005999, 24'h010223, 24'h130459, 3'b000, 1'b0);

    // Asynchronous reset in the middle of an edit
    vif.rtc_time_in = 24'h140000; vif.edit_mode = 2'b11;
    cyc("time_entry3", 24'h140000, 24'h010223, 24'h130459, 3'b000, 1'b1);
    vif.edit_pos = 2'b11; vif.boton_ed = 4'b0001;
    cyc("hh_up_15", 24'h150000, 24'h010223, 24'h130459, 3'b000, 1'b1);
    vif.boton_ed = 4'b0000;
    cyc("hh15_release", 24'h150000, 24'h010223, 24'h130459, 3'b000, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    push_exp("async_reset", 24'h000000, 24'h010100, 24'h000000, 3'b000, 1'b0);
    cyc("reset_hold", 24'h000000, 24'h010100, 24'h000000, 3'b000, 1'b0);
    vif.edit_mode = 2'b00;
    reset = 1'b1;
    cyc("no_wr_after_rst", 24'h000000, 24'h010100, 24'h000000, 3'b000, 1'b0);
    cyc("no_wr_after_rst2", 24'h000000, 24'h010100, 24'h000000, 3'b000, 1'b0);

    for (int i = 0; i < 10 && sb_q.size() > 0; i++)
      @(negedge clk);
    #1;
    if (sb_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
